run_ctrl: RTL and testbench

//  Responder end of the top-level req/ack start handshake of the DUT. It launches the core at the current

---
 rtl/run_ctrl_pkg.sv | 15 +
 rtl/run_ctrl_watchdog.sv | 32 +++
 rtl/run_ctrl.sv | 90 +++++++++
 tb/tb_run_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and width defaults for the run controller, decoder and bench.
package run_ctrl_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int CNT_W_DEF      = 16;
  localparam int MAX_CYCLES_DEF = 65535;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } run_state_e;

endpackage

// File: rtl/run_ctrl_watchdog.sv
// Saturating run-cycle counter with clear/enable; expired flags the cycle
// in which the count is about to reach MAX_CYCLES.
module run_watchdog
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  logic [CNT_W:0] count_inc;

  // One extra bit so the compare cannot alias when MAX_C is all ones.
  assign count_inc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
  assign expired   = (count_inc == {1'b0, MAX_C});

  // Counter: clear wins over enable, hold once saturated.
  always_ff @(posedge clk) begin
    if (reset)                     count <= '0;
    else if (clr)                  count <= '0;
    else if (en && count != MAX_C) count <= count_inc[CNT_W-1:0];
  end

endmodule

// File: rtl/run_ctrl.sv
// Responder side of the req/ack start handshake: launches the core at the
// current start address, runs until halt or watchdog, then pulses ack. The
// next run resumes at the instruction after the last halt.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              ack,
  input  logic              halt,
  input  logic [ADDR_W-1:0] halt_pc,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              run_en,
  output logic [CNT_W-1:0]  cycles,
  output logic              timeout
);

  run_state_e        state, state_nx;
  logic [ADDR_W-1:0] start_addr;
  logic [CNT_W-1:0]  count;
  logic              expired;

  run_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (state == LAUNCH),
    .en      (state == RUN),
    .count   (count),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: req only matters in IDLE and DONE; halt beats the watchdog.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (req) state_nx = LAUNCH;
      LAUNCH: state_nx = RUN;
      RUN:    if (halt || expired) state_nx = DONE;
      DONE:   state_nx = req ? LAUNCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes decode straight from state, so run_en drops the cycle ack rises.
  always_comb begin
    ack     = (state == DONE);
    pc_load = (state == LAUNCH);
    run_en  = (state == RUN);
  end

  // Run bookkeeping: start address, last run length and timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_addr <= '0;
      cycles     <= '0;
      timeout    <= 1'b0;
    end else begin
      if (state == LAUNCH) begin
        cycles  <= '0;
        timeout <= 1'b0;
      end else if (state == RUN) begin
        if (halt) begin
          start_addr <= halt_pc + ADDR_W'(1);
          cycles     <= count + CNT_W'(1);
        end else if (expired) begin
          timeout <= 1'b1;
          cycles  <= CNT_W'(MAX_CYCLES);
        end
      end
    end
  end

  assign pc_load_val = start_addr;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: a long-watchdog and a short-watchdog (16) instance share
// stimulus; a run-level model predicts both every cycle, and literal checks
// pin the model at the interesting points.
module tb_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int AW = 10;
  localparam int CW = 16;
  localparam int MAX_A = 65535;
  localparam int MAX_B = 16;

  logic clk = 1'b0;
  logic reset, req, halt;
  logic [AW-1:0] halt_pc;

  logic          ack_a, pcl_a, ren_a, to_a;
  logic [AW-1:0] pclv_a;
  logic [CW-1:0] cyc_a;
  logic          ack_b, pcl_b, ren_b, to_b;
  logic [AW-1:0] pclv_b;
  logic [CW-1:0] cyc_b;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  run_ctrl #(.ADDR_W(AW), .MAX_CYCLES(MAX_A), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset), .req(req), .ack(ack_a), .halt(halt),
    .halt_pc(halt_pc), .pc_load(pcl_a), .pc_load_val(pclv_a),
    .run_en(ren_a), .cycles(cyc_a), .timeout(to_a)
  );

  run_ctrl #(.ADDR_W(AW), .MAX_CYCLES(MAX_B), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset), .req(req), .ack(ack_b), .halt(halt),
    .halt_pc(halt_pc), .pc_load(pcl_b), .pc_load_val(pclv_b),
    .run_en(ren_b), .cycles(cyc_b), .timeout(to_b)
  );

  // Run-level model: phase 0 idle, 1 launching, 2 running (elapsed = RUN
  // cycles already completed), 3 finished.
  typedef struct {
    int phase;
    int elapsed;
    int last_len;
    int timed_out;
    int start;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t step(mdl_t m, bit rst, bit rq, bit h, int hpc, int maxc);
    mdl_t n = m;
    if (rst) begin
      n.phase = 0; n.elapsed = 0; n.last_len = 0; n.timed_out = 0; n.start = 0;
      return n;
    end
    case (m.phase)
      0: if (rq) n.phase = 1;
      1: begin
        n.phase = 2; n.elapsed = 0; n.last_len = 0; n.timed_out = 0;
      end
      2: begin
        n.elapsed = m.elapsed + 1;
        if (h) begin
          n.phase = 3; n.last_len = n.elapsed; n.start = (hpc + 1) % (1 << AW);
        end else if (n.elapsed == maxc) begin
          n.phase = 3; n.last_len = maxc; n.timed_out = 1;
        end
      end
      default: n.phase = rq ? 1 : 0;
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, reset, req, halt, int'(halt_pc), MAX_A);
    mb <= step(mb, reset, req, halt, int'(halt_pc), MAX_B);
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("a.ack",     int'(ack_a),  int'(ma.phase == 3));
      chk("a.pc_load", int'(pcl_a),  int'(ma.phase == 1));
      chk("a.run_en",  int'(ren_a),  int'(ma.phase == 2));
      chk("a.pc_val",  int'(pclv_a), ma.start);
      chk("a.cycles",  int'(cyc_a),  ma.last_len);
      chk("a.timeout", int'(to_a),   ma.timed_out);
      chk("b.ack",     int'(ack_b),  int'(mb.phase == 3));
      chk("b.pc_load", int'(pcl_b),  int'(mb.phase == 1));
      chk("b.run_en",  int'(ren_b),  int'(mb.phase == 2));
      chk("b.pc_val",  int'(pclv_b), mb.start);
      chk("b.cycles",  int'(cyc_b),  mb.last_len);
      chk("b.timeout", int'(to_b),   mb.timed_out);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; halt = 1'b0; halt_pc = '0;
    tick(2);
    reset = 1'b0; chk_en = 1'b1;
    tick();
    // 1. reset state
    chk("rst.ack", int'(ack_a), 0);
    chk("rst.run_en", int'(ren_a), 0);
    chk("rst.pc_load", int'(pcl_a), 0);
    chk("rst.timeout", int'(to_a), 0);
    chk("rst.pc_val", int'(pclv_a), 0);

    // 2. basic run, halt at pc 73 in RUN cycle 40 (b times out at 16)
    req = 1'b1; tick(); req = 1'b0;
    chk("s2.pc_load", int'(pcl_a), 1);
    chk("s2.pc_val", int'(pclv_a), 0);
    tick();
    chk("s2.run_en", int'(ren_a), 1);
    tick(15);
    tick();
    chk("s2.b_ack", int'(ack_b), 1);
    chk("s2.b_timeout", int'(to_b), 1);
    tick(23);
    halt = 1'b1; halt_pc = AW'(73);
    tick(); halt = 1'b0;
    chk("s2.ack", int'(ack_a), 1);
    chk("s2.run_en_off", int'(ren_a), 0);
    tick();
    chk("s2.cycles", int'(cyc_a), 40);
    chk("s2.timeout", int'(to_a), 0);
    chk("s2.pc_val", int'(pclv_a), 74);

    // 3. second program from 74, halt at 79 in RUN cycle 10
    req = 1'b1; tick(); req = 1'b0;
    chk("s3.pc_load", int'(pcl_a), 1);
    chk("s3.pc_val", int'(pclv_a), 74);
    tick(10);
    halt = 1'b1; halt_pc = AW'(79);
    tick(); halt = 1'b0;
    chk("s3.ack", int'(ack_a), 1);
    tick();
    chk("s3.pc_val", int'(pclv_a), 80);
    chk("s3.cycles", int'(cyc_a), 10);

    // 4. watchdog on b: ack after 16 RUN cycles, start kept at 80
    req = 1'b1; tick(); req = 1'b0;
    tick(16);
    chk("s4.b_run16", int'(ren_b), 1);
    tick();
    chk("s4.b_ack", int'(ack_b), 1);
    chk("s4.b_timeout", int'(to_b), 1);
    chk("s4.b_cycles", int'(cyc_b), 16);
    chk("s4.b_pc_val", int'(pclv_b), 80);
    halt = 1'b1; halt_pc = AW'(5);   // ends run on a only
    tick(); halt = 1'b0;
    tick();
    // simultaneous halt and watchdog on RUN cycle 16
    req = 1'b1; tick(); req = 1'b0;
    tick(16);
    halt = 1'b1; halt_pc = AW'(200);
    tick(); halt = 1'b0;
    chk("s4.sim_ack", int'(ack_b), 1);
    chk("s4.sim_timeout", int'(to_b), 0);
    chk("s4.sim_pc_val", int'(pclv_b), 201);
    chk("s4.sim_cycles", int'(cyc_b), 16);
    tick();

    // 5. req held high, toggled in RUN, halt at last address wraps to 0
    req = 1'b1; tick();
    chk("s5.pc_load", int'(pcl_a), 1);
    tick(5);
    req = 1'b0; tick(); req = 1'b1;
    chk("s5.still_run", int'(ren_a), 1);
    halt = 1'b1; halt_pc = AW'((1 << AW) - 1);
    tick(); halt = 1'b0;
    chk("s5.ack", int'(ack_a), 1);
    chk("s5.wrap", int'(pclv_a), 0);
    tick();
    chk("s5.relaunch", int'(pcl_a), 1);
    tick(); req = 1'b0;
    tick(2);
    halt = 1'b1; halt_pc = AW'(9);
    tick(); halt = 1'b0;
    tick();
    chk("s5.pc_val", int'(pclv_a), 10);

    // 6. reset in RUN cycle 5
    req = 1'b1; tick(); req = 1'b0;
    tick(5);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("s6.run_en", int'(ren_a), 0);
    chk("s6.ack", int'(ack_a), 0);
    chk("s6.pc_val", int'(pclv_a), 0);
    tick(3);
    req = 1'b1; tick(); req = 1'b0;
    chk("s6.pc_load", int'(pcl_a), 1);
    chk("s6.pc_val0", int'(pclv_a), 0);
    tick(3);
    halt = 1'b1; halt_pc = AW'(3);
    tick(); halt = 1'b0;
    tick(2);
    chk("s6.pc_val4", int'(pclv_a), 4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
